// File: rtl/present_cipher_core.sv
// rtl/present_cipher_core.sv - iterative PRESENT encrypt/decrypt engine, 80/128-bit key, optional PRESENT_KEYCACHE_EN
`timescale 1ns/1ps

module present_cipher_core #(
    parameter int KEY_BITS = 80,
    parameter int ROUNDS   = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_decrypt,
    input  logic [KEY_BITS-1:0] in_key,
    input  logic [63:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_data,
    output logic                busy
);

    // Round-counter injection point inside the key register differs per key size.
    localparam int         CNT_LSB  = (KEY_BITS == 128) ? 62 : 15;
    localparam logic [4:0] LAST_RND = 5'(ROUNDS);

    generate
        if (KEY_BITS != 80 && KEY_BITS != 128) begin : g_bad_key_bits
            $error("present_cipher_core: KEY_BITS must be 80 or 128");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        ENC,
        DEC,
        HOLD
    } fsm_t;

    fsm_t                fsm_q;
    fsm_t                fsm_d;
    logic [63:0]         state_q;
    logic [KEY_BITS-1:0] key_q;
    logic [4:0]          rnd_q;
    logic                out_valid_q;
    logic [63:0]         out_data_q;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: sbox4 = 4'hC;
            4'h1: sbox4 = 4'h5;
            4'h2: sbox4 = 4'h6;
            4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'h9;
            4'h5: sbox4 = 4'h0;
            4'h6: sbox4 = 4'hA;
            4'h7: sbox4 = 4'hD;
            4'h8: sbox4 = 4'h3;
            4'h9: sbox4 = 4'hE;
            4'hA: sbox4 = 4'hF;
            4'hB: sbox4 = 4'h8;
            4'hC: sbox4 = 4'h4;
            4'hD: sbox4 = 4'h7;
            4'hE: sbox4 = 4'h1;
            default: sbox4 = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox4 = 4'h5;
            4'h1: inv_sbox4 = 4'hE;
            4'h2: inv_sbox4 = 4'hF;
            4'h3: inv_sbox4 = 4'h8;
            4'h4: inv_sbox4 = 4'hC;
            4'h5: inv_sbox4 = 4'h1;
            4'h6: inv_sbox4 = 4'h2;
            4'h7: inv_sbox4 = 4'hD;
            4'h8: inv_sbox4 = 4'hB;
            4'h9: inv_sbox4 = 4'h4;
            4'hA: inv_sbox4 = 4'h6;
            4'hB: inv_sbox4 = 4'h3;
            4'hC: inv_sbox4 = 4'h0;
            4'hD: inv_sbox4 = 4'h7;
            4'hE: inv_sbox4 = 4'h9;
            default: inv_sbox4 = 4'hA;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = sbox4(s[4*n +: 4]);
        end
        return o;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
        end
        return o;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 63; i++) begin
            o[6'((i * 16) % 63)] = s[6'(i)];
        end
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
        logic [63:0] o;
        for (int i = 0; i < 63; i++) begin
            o[6'(i)] = s[6'((i * 16) % 63)];
        end
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [KEY_BITS-1:0] key_fwd(input logic [KEY_BITS-1:0] k, input logic [4:0] i);
        logic [KEY_BITS-1:0] t;
        t = {k[KEY_BITS-62:0], k[KEY_BITS-1:KEY_BITS-61]};
        t[KEY_BITS-1 -: 4] = sbox4(t[KEY_BITS-1 -: 4]);
        if (KEY_BITS == 128) begin
            t[KEY_BITS-5 -: 4] = sbox4(t[KEY_BITS-5 -: 4]);
        end
        t[CNT_LSB +: 5] = t[CNT_LSB +: 5] ^ i;
        return t;
    endfunction

    // Undo key_fwd step by step in reverse order: counter, S-box, rotation.
    function automatic logic [KEY_BITS-1:0] key_inv(input logic [KEY_BITS-1:0] k, input logic [4:0] i);
        logic [KEY_BITS-1:0] t;
        t = k;
        t[CNT_LSB +: 5] = t[CNT_LSB +: 5] ^ i;
        t[KEY_BITS-1 -: 4] = inv_sbox4(t[KEY_BITS-1 -: 4]);
        if (KEY_BITS == 128) begin
            t[KEY_BITS-5 -: 4] = inv_sbox4(t[KEY_BITS-5 -: 4]);
        end
        return {t[60:0], t[KEY_BITS-1:61]};
    endfunction

    logic [63:0]         round_key;
    logic [63:0]         enc_next;
    logic [63:0]         dec_next;
    logic [KEY_BITS-1:0] key_next_fwd;
    logic [KEY_BITS-1:0] key_next_inv;
    logic                last_rnd;
    logic                first_rnd;
    logic                accept;
    logic                cache_hit;
    logic [KEY_BITS-1:0] hit_k32;

    assign round_key    = key_q[KEY_BITS-1 -: 64];
    assign key_next_fwd = key_fwd(key_q, rnd_q);
    assign key_next_inv = key_inv(key_q, rnd_q);
    assign enc_next     = p_layer(sbox_layer(state_q ^ round_key));
    assign dec_next     = inv_sbox_layer(inv_p_layer(state_q)) ^ key_next_inv[KEY_BITS-1 -: 64];
    assign last_rnd     = (rnd_q == LAST_RND);
    assign first_rnd    = (rnd_q == 5'd1);
    assign accept       = in_valid && in_ready;

`ifdef PRESENT_KEYCACHE_EN
    logic [KEY_BITS-1:0] cache_key;
    logic [KEY_BITS-1:0] cache_k32;
    logic [KEY_BITS-1:0] orig_key;
    logic                cache_vld;

    assign cache_hit = cache_vld && (in_key == cache_key);
    assign hit_k32   = cache_k32;

    // Remember the last fully expanded schedule so a decrypt under the same key can skip KEYEXP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_key <= '0;
            cache_k32 <= '0;
            orig_key  <= '0;
            cache_vld <= 1'b0;
        end else begin
            if (accept) begin
                orig_key <= in_key;
            end
            if ((fsm_q == ENC || fsm_q == KEYEXP) && last_rnd) begin
                cache_key <= orig_key;
                cache_k32 <= key_next_fwd;
                cache_vld <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_k32   = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state selection.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    if (!in_decrypt) begin
                        fsm_d = ENC;
                    end else if (cache_hit) begin
                        fsm_d = DEC;
                    end else begin
                        fsm_d = KEYEXP;
                    end
                end
            end
            KEYEXP: if (last_rnd) fsm_d = DEC;
            ENC:    if (last_rnd) fsm_d = HOLD;
            DEC:    if (first_rnd) fsm_d = HOLD;
            HOLD:   if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Datapath: one cipher round or key-schedule step per cycle, result held until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= '0;
            key_q       <= '0;
            rnd_q       <= 5'd1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        // Block is latched for both modes; decrypt whitens it once K32 is known.
                        state_q <= in_data;
                        key_q   <= in_key;
                        rnd_q   <= 5'd1;
                        if (in_decrypt && cache_hit) begin
                            state_q <= in_data ^ hit_k32[KEY_BITS-1 -: 64];
                            key_q   <= hit_k32;
                            rnd_q   <= LAST_RND;
                        end
                    end
                end
                KEYEXP: begin
                    key_q <= key_next_fwd;
                    if (last_rnd) begin
                        state_q <= state_q ^ key_next_fwd[KEY_BITS-1 -: 64];
                        rnd_q   <= LAST_RND;
                    end else begin
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                ENC: begin
                    state_q <= enc_next;
                    key_q   <= key_next_fwd;
                    if (last_rnd) begin
                        out_data_q  <= enc_next ^ key_next_fwd[KEY_BITS-1 -: 64];
                        out_valid_q <= 1'b1;
                        rnd_q       <= 5'd1;
                    end else begin
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                DEC: begin
                    state_q <= dec_next;
                    key_q   <= key_next_inv;
                    if (first_rnd) begin
                        out_data_q  <= dec_next;
                        out_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 5'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_present_cipher_core.sv
// tb/tb_present_cipher_core.sv - self-checking bench for present_cipher_core (80- and 128-bit instances)
`timescale 1ns/1ps

module tb_present_cipher_core;

`ifdef PRESENT_KEYCACHE_EN
    localparam int LAT_HIT = 31;
`else
    localparam int LAT_HIT = 62;
`endif
    localparam int LAT_ENC  = 31;
    localparam int LAT_MISS = 62;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    logic         clk;
    logic         rst;
    logic         sel;
    logic         in_valid;
    logic         in_decrypt;
    logic [127:0] in_key;
    logic [63:0]  in_data;
    logic         out_ready;

    logic         in_ready_a, out_valid_a, busy_a;
    logic [63:0]  out_data_a;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [63:0]  out_data_b;

    logic         in_ready_s, out_valid_s, busy_s;
    logic [63:0]  out_data_s;
    logic         out_ready_a_w, out_ready_b_w;

    int errs;
    int checks;
    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];

    assign out_ready_a_w = out_ready & ~sel;
    assign out_ready_b_w = out_ready & sel;
    assign in_ready_s    = sel ? in_ready_b  : in_ready_a;
    assign out_valid_s   = sel ? out_valid_b : out_valid_a;
    assign busy_s        = sel ? busy_b      : busy_a;
    assign out_data_s    = sel ? out_data_b  : out_data_a;

    present_cipher_core #(.KEY_BITS(80), .ROUNDS(31)) u_dut80 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid & ~sel),
        .in_ready   (in_ready_a),
        .in_decrypt (in_decrypt),
        .in_key     (in_key[79:0]),
        .in_data    (in_data),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready_a_w),
        .out_data   (out_data_a),
        .busy       (busy_a)
    );

    present_cipher_core #(.KEY_BITS(128), .ROUNDS(31)) u_dut128 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid & sel),
        .in_ready   (in_ready_b),
        .in_decrypt (in_decrypt),
        .in_key     (in_key),
        .in_data    (in_data),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b_w),
        .out_data   (out_data_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sinv(input logic [3:0] v);
        for (int j = 0; j < 16; j++) begin
            if (SB[j] == v) return 4'(j);
        end
        return 4'h0;
    endfunction

    function automatic logic [63:0] slayer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) begin
            o[6'(4*n) +: 4] = inv ? sinv(s[6'(4*n) +: 4]) : SB[s[6'(4*n) +: 4]];
        end
        return o;
    endfunction

    // Bit i of nibble-column form: destination 16*(i mod 4) + i/4.
    function automatic logic [63:0] player(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) begin
            if (inv) o[6'(i)] = s[6'(16 * (i % 4) + i / 4)];
            else     o[6'(16 * (i % 4) + i / 4)] = s[6'(i)];
        end
        return o;
    endfunction

    // Reference cipher: precompute all 32 round keys, then run them forward or backward.
    function automatic logic [63:0] model(input bit dec, input int kb, input logic [127:0] key, input logic [63:0] din);
        logic [127:0] k;
        logic [127:0] t;
        logic [63:0]  rk [33];
        logic [63:0]  s;
        int           base;
        base = (kb == 128) ? 62 : 15;
        k = key;
        for (int r = 1; r <= 32; r++) begin
            for (int j = 0; j < 64; j++) rk[r][6'(j)] = k[7'(kb - 64 + j)];
            t = '0;
            for (int j = 0; j < kb; j++) t[7'(j)] = k[7'((j + kb - 61) % kb)];
            t[7'(kb - 1) -: 4] = SB[t[7'(kb - 1) -: 4]];
            if (kb == 128) t[7'(kb - 5) -: 4] = SB[t[7'(kb - 5) -: 4]];
            t[7'(base) +: 5] = t[7'(base) +: 5] ^ 5'(r);
            k = t;
        end
        s = din;
        if (!dec) begin
            for (int r = 1; r <= 31; r++) s = player(slayer(s ^ rk[r], 1'b0), 1'b0);
            s = s ^ rk[32];
        end else begin
            s = s ^ rk[32];
            for (int r = 31; r >= 1; r--) s = slayer(player(s, 1'b1), 1'b1) ^ rk[r];
        end
        return s;
    endfunction

    // Output scoreboards: every cycle a result is presented it must equal the oldest expectation.
    always @(negedge clk) begin
        if (out_valid_a) begin
            chk("a_queue_nonempty", 64'(exp_a.size() > 0), 64'd1);
            if (exp_a.size() > 0) begin
                chk("a_out_data", out_data_a, exp_a[0]);
                if (out_ready_a_w) void'(exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_b) begin
            chk("b_queue_nonempty", 64'(exp_b.size() > 0), 64'd1);
            if (exp_b.size() > 0) begin
                chk("b_out_data", out_data_b, exp_b[0]);
                if (out_ready_b_w) void'(exp_b.pop_front());
            end
        end
    end

    task automatic run(input bit s, input bit dec, input logic [127:0] key, input logic [63:0] din,
                       input bit has_lit, input logic [63:0] lit, input int lat, input int hold,
                       output logic [63:0] result);
        logic [63:0] e;
        int n;
        bit got;
        @(posedge clk); #1;
        sel = s;
        #0;
        chk("ready_before_accept", 64'(in_ready_s), 64'd1);
        e = model(dec, s ? 128 : 80, key, din);
        if (has_lit) chk("model_vs_literal", e, lit);
        result = e;
        if (s) exp_b.push_back(e); else exp_a.push_back(e);
        in_valid   = 1'b1;
        in_decrypt = dec;
        in_key     = key;
        in_data    = din;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_decrypt = ~dec;
        in_key     = {$urandom, $urandom, $urandom, $urandom};
        in_data    = {$urandom, $urandom};
        chk("ready_low_after_accept", 64'(in_ready_s), 64'd0);
        chk("busy_after_accept", 64'(busy_s), 64'd1);
        n = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk); #1;
            n++;
            got = out_valid_s;
        end
        chk("latency_edges", 64'(n), 64'(lat));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(out_valid_s), 64'd1);
            chk("hold_in_ready", 64'(in_ready_s), 64'd0);
            chk("hold_busy", 64'(busy_s), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_out_valid", 64'(out_valid_s), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready_s), 64'd1);
        chk("post_hs_busy", 64'(busy_s), 64'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic [127:0] k9;
        errs       = 0;
        checks     = 0;
        rst        = 1'b1;
        sel        = 1'b0;
        in_valid   = 1'b0;
        in_decrypt = 1'b0;
        in_key     = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_a_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_a_busy", 64'(busy_a), 64'd0);
        chk("rst_a_out_data", out_data_a, 64'd0);
        chk("rst_b_out_valid", 64'(out_valid_b), 64'd0);
        chk("rst_b_in_ready", 64'(in_ready_b), 64'd1);
        chk("rst_b_out_data", out_data_b, 64'd0);
        rst = 1'b0;

        // 80-bit key: known-answer vectors, backpressure, cache hit then miss.
        run(1'b0, 1'b0, 128'h0, 64'h0, 1'b1, 64'h5579C1387B228445, LAT_ENC, 0, r);
        run(1'b0, 1'b0, 128'hFFFF_FFFFFFFF_FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h3333DCD3213210D2, LAT_ENC, 10, r);
        run(1'b0, 1'b1, 128'hFFFF_FFFFFFFF_FFFFFFFF, 64'h3333DCD3213210D2, 1'b1, 64'hFFFFFFFFFFFFFFFF, LAT_HIT, 0, r);
        run(1'b0, 1'b1, 128'h0, 64'h5579C1387B228445, 1'b1, 64'h0, LAT_MISS, 0, r);

        // Reset in the middle of an encryption at round 15.
        @(posedge clk); #1;
        sel        = 1'b0;
        in_valid   = 1'b1;
        in_decrypt = 1'b0;
        in_key     = 128'h0;
        in_data    = 64'h0123456789ABCDEF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("midop_busy", 64'(busy_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid_a), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_a), 64'd1);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        #1;
        rst = 1'b0;
        run(1'b0, 1'b0, 128'hFFFF_FFFFFFFF_FFFFFFFF, 64'h0, 1'b1, 64'hE72C46C0F5945049, LAT_ENC, 0, r);
        run(1'b0, 1'b1, 128'hFFFF_FFFFFFFF_FFFFFFFF, 64'hE72C46C0F5945049, 1'b1, 64'h0, LAT_HIT, 0, r);

        // 128-bit key.
        run(1'b1, 1'b0, 128'h0, 64'h0, 1'b1, 64'h96DB702A2E6900AF, LAT_ENC, 0, r);
        run(1'b1, 1'b1, 128'h0, 64'h96DB702A2E6900AF, 1'b1, 64'h0, LAT_HIT, 0, r);
        k9 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        run(1'b1, 1'b0, k9, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0, LAT_ENC, 3, r);
        run(1'b1, 1'b1, k9, r, 1'b1, 64'hDEADBEEFCAFEF00D, LAT_HIT, 0, r);
        run(1'b1, 1'b1, 128'h0, 64'h96DB702A2E6900AF, 1'b1, 64'h0, LAT_MISS, 0, r);

        repeat (2) @(posedge clk);
        #1;
        chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/present_cipher_core.md
Name: present_cipher_core

Overview:
- Iterative PRESENT block-cipher engine, one round per clock, 64-bit block.
- Generalises the single-shot encryptor in three ways: key width selectable at 80 or 128 bits, runtime encrypt/decrypt mode, and valid/ready handshakes on input and output.
- Sits between the command/DMA front end and the output FIFO of the crypto datapath.

Parameters:
- KEY_BITS, 80, key length. Legal values are 80 and 128; any other value is an elaboration error.
- ROUNDS, 31, number of S-box rounds. The final key whitening is always added after the last round.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  core can accept a request
- in_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled on accept
- in_key  in  KEY_BITS  cipher key; sampled on accept
- in_data  in  64  plaintext or ciphertext; sampled on accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  64  result block
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: FSM=IDLE, rnd=1, out_valid=0, out_data=0, busy=0, in_ready=1.
  - Reset is honoured mid-operation; the block in flight is discarded.
- FSM states: IDLE, KEYEXP, ENC, DEC, HOLD.
- in_ready = (FSM==IDLE). A request is accepted on in_valid & in_ready.
- Key update, forward, round i (applied to key register K):
  - 80-bit: rotate left 61; S-box on bits [79:76]; bits [19:15] ^= i.
  - 128-bit: rotate left 61; S-box on bits [127:124] and [123:120]; bits [66:62] ^= i.
  - Round key = K[KEY_BITS-1 -: 64].
- Key update, inverse, round i: exact reverse order of the forward update — XOR i, then inverse S-box on the same nibbles, then rotate right 61.
- Encrypt path:
  - On accept: state<=in_data, K<=in_key, rnd<=1, go to ENC.
  - ENC, each cycle: state<=pLayer(S(state^rk)), K<=fwd(K,rnd), rnd<=rnd+1.
  - On the rnd==ROUNDS cycle: out_data<=nextstate^nextkey[top 64], out_valid<=1, go to HOLD.
  - Latency: out_valid is high 31 clock edges after the accept edge.
- Decrypt path:
  - On accept: K<=in_key, rnd<=1, go to KEYEXP.
  - KEYEXP runs the forward schedule for 31 cycles, producing K32.
  - On the last KEYEXP cycle: state<=in_data^nextkey[top 64], rnd<=ROUNDS, go to DEC.
  - DEC, each cycle: K<=inv(K,rnd); state<=invS(invP(state))^inv(K,rnd)[top 64]; rnd<=rnd-1.
  - On the rnd==1 cycle: out_data<=nextstate, out_valid<=1, go to HOLD.
  - Latency: 62 edges after the accept edge.
- HOLD: out_data and out_valid are stable. On out_valid & out_ready: out_valid<=0, go to IDLE.
  - in_ready is low in HOLD, so no accept can coincide with the output handshake. The next accept happens at the earliest one cycle later.
- Counter: rnd is 5-bit and never wraps. It runs 1..31 in KEYEXP and ENC, and 31..1 in DEC.
- in_key, in_data and in_decrypt are ignored outside the accept cycle.
- out_valid must not drop without out_ready; out_data must not change while out_valid=1.

Optional Feature:
- Macro: PRESENT_KEYCACHE_EN.
- When defined:
  - Registers cache_key (KEY_BITS), cache_k32 (KEY_BITS) and cache_vld, all cleared by reset.
  - Every completed ENC or KEYEXP run writes the original key and K32 into the cache and sets cache_vld.
  - A decrypt accept with cache_vld & in_key==cache_key skips KEYEXP: state<=in_data^cache_k32[top 64], K<=cache_k32, rnd<=ROUNDS, go to DEC. Latency drops to 31 edges.
  - A key mismatch takes the normal 62-edge path.
- When undefined: no cache registers; decrypt latency is always 62 edges.

Test Plan:
- KEY_BITS=80, encrypt, key 0, pt 0 -> out_data 5579C1387B228445, out_valid 31 edges after accept.
- KEY_BITS=80, encrypt, key all-F, pt all-F -> 3333DCD3213210D2; then decrypt of that result with the same key -> FFFFFFFFFFFFFFFF after 62 edges (31 with PRESENT_KEYCACHE_EN).
- KEY_BITS=128, encrypt, key 0, pt 0 -> 96DB702A2E6900AF; decrypt of the result -> 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data held, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst pulsed at ENC rnd=15 -> out_valid=0 and in_ready=1 immediately. A following request (key all-F, pt 0) -> E72C46C0F5945049 with no corruption.
- PRESENT_KEYCACHE_EN: two back-to-back decrypts, the second with a different key -> second request takes 62 edges and decrypts correctly.
